stream_demux_1_to_n: RTL and testbench
======================================

# stream_demux_1_to_n

Registered, flow-controlled 1-to-N demultiplexer replacing the fixed combinational 1-to-8 demux in the gyro tester datapath. It takes one valid/ready input stream plus a channel select and routes each accepted word to one of N_CH output channels. Each channel has a single-entry output register. A broadcast mode delivers one word to all channels, and out-of-range selects are dropped and counted. It sits between the command/stimulus sequencer and the per-channel gyro drive logic.

## Interface
- N_CH, 8, number of output channels; legal range 2..32
- DATA_W, 1, payload width per word
- SEL_W, $clog2(N_CH), select width; derived localparam, not overridable
- CNT_W, 8, width of the dropped-word counter
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low; deassertion synchronised externally
- in_valid  in  1  input word present
- in_ready  out  1  block accepts the word this cycle
- in_data  in  DATA_W  payload
- in_sel  in  SEL_W  destination channel
- in_bcast  in  1  1 = deliver to all channels, in_sel ignored
- out_valid  out  N_CH  per-channel word present
- out_ready  in  N_CH  per-channel consumer accepts
- out_data  out  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- err_clr  in  1  synchronous clear of sel_err and drop_cnt
- sel_err  out  1  sticky: an out-of-range select was dropped
- drop_cnt  out  CNT_W  saturating count of dropped words

## Operation
- Transfer: in_valid & in_ready at a rising edge.
- Channel i is free when ~out_valid[i], or when out_valid[i] & out_ready[i] (drained this cycle).
- in_ready, combinational from in_bcast, in_sel, and the channel-free signals:
  - unicast, in_sel < N_CH: channel in_sel is free
  - broadcast: every channel is free
  - unicast, in_sel >= N_CH: 1; the word is dropped
- Unicast accept: out_data[in_sel] <= in_data, out_valid[in_sel] <= 1. Other channels are untouched.
- Broadcast accept: all out_data <= in_data and all out_valid <= 1 in the same cycle. The load is atomic; there is no partial broadcast.
- Dropped accept: no channel changes, sel_err <= 1, drop_cnt increments and saturates at 2^CNT_W-1.
- Channel drain: out_valid[i] & out_ready[i] with no new load clears out_valid[i]. out_data[i] holds its last value.
- Simultaneous drain and load on the same channel: the channel keeps out_valid = 1 with the new data. Full throughput is one word per cycle per channel.
- err_clr has priority over a same-cycle drop:
  - err_clr alone: sel_err <= 0, drop_cnt <= 0
  - err_clr with a drop: sel_err <= 1, drop_cnt <= 1
- in_ready must not depend on in_valid.
- out_valid/out_data of a waiting channel stay stable until out_ready.
- Power-of-two N_CH: out-of-range selects cannot occur. Drop logic is still present but is unreachable.

## Timing
- Reset (rst_n = 0, takes effect immediately):
  - out_valid = 0, out_data = 0, sel_err = 0, drop_cnt = 0
  - in_ready then follows the free rules. After reset all channels are free, so in_ready = 1.
- Latency: a word accepted at edge k shows out_valid = 1 after edge k (visible in cycle k+1).
- Back-pressure:
  - An occupied channel with out_ready = 0 stalls unicast input to that channel and all broadcasts.
  - Unicast traffic to other channels continues.
- Reset mid-operation: pending output words are discarded and no handshake completes. The first transfer is possible in the first cycle with rst_n = 1.
- Combinational paths: in_sel/in_bcast/out_ready -> in_ready. No combinational path from in_* to out_*.

## Test plan
- Reset, then unicast in_data=1 with in_sel=0..7 in consecutive cycles, all out_ready=1 (N_CH=8) -> out_valid[s] is a one-cycle pulse in the cycle after each accept, data=1; in_ready stays 1 throughout.
- out_ready[3]=0, two unicasts to ch3, then one to ch5 -> first word accepted, then in_ready=0 for ch3; with in_sel=5, in_ready=1. Raise out_ready[3] -> second ch3 word accepted on the same edge ch3 drains; out_valid[3] stays 1 with the new data.
- N_CH=5, DATA_W=4: in_sel=6, in_data=4'hA -> accepted, no out_valid change; sel_err=1, drop_cnt=1. Repeat 300 times with CNT_W=8 -> drop_cnt saturates at 255.
- err_clr and an in_sel=7 drop in the same cycle (N_CH=5) -> sel_err=1, drop_cnt=1. Next cycle err_clr alone -> both 0.
- Broadcast 4'h5 with out_ready[2]=0 and channel 2 occupied -> in_ready=0 and no channel loads. Release out_ready[2] -> all N_CH channels load 4'h5 on the same edge.
- Assert rst_n=0 mid-stream with three channels holding words -> out_valid=0 and out_data=0 immediately. After release, in_ready=1 in the first cycle.

Source files
------------

// File: rtl/stream_demux_1_to_n_if.sv
// Handshake bundle between a 1-to-N stream demux and its producer/consumers.
// master drives the input stream and per-channel out_ready; slave is the demux.
interface stream_demux_1_to_n_if #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 1
);
  localparam int SEL_W = $clog2(N_CH);

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_bcast;
  logic [N_CH-1:0]          out_valid;
  logic [N_CH-1:0]          out_ready;
  logic [N_CH*DATA_W-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_demux_1_to_n.sv
// Registered 1-to-N stream demux with broadcast and out-of-range drop counting; one-cycle latency.
// in_ready stalls only when the target channel (or any channel, for broadcast) is full and not draining.
module stream_demux_1_to_n #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  stream_demux_1_to_n_if.slave     bus,
  input  logic                     err_clr,
  output logic                     sel_err,
  output logic [CNT_W-1:0]         drop_cnt
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH-1:0]              valid_q;
  logic [N_CH-1:0][DATA_W-1:0]  data_q;

  logic [N_CH-1:0] ch_free;
  logic [N_CH-1:0] sel_hit;
  logic [N_CH-1:0] load;
  logic            sel_ok;
  logic            in_ready_c;
  logic            xfer;
  logic            drop;

  // One-hot decode of in_sel; an empty decode means the select is out of range.
  always_comb begin
    ch_free    = ~valid_q | bus.out_ready;
    sel_hit    = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_hit[i] = (bus.in_sel == SEL_W'(i));
    end
    sel_ok     = |sel_hit;

    if (bus.in_bcast) begin
      in_ready_c = &ch_free;
    end else if (sel_ok) begin
      in_ready_c = |(sel_hit & ch_free);
    end else begin
      in_ready_c = 1'b1;
    end

    xfer = bus.in_valid & in_ready_c;
    load = '0;
    if (xfer) begin
      load = bus.in_bcast ? {N_CH{1'b1}} : sel_hit;
    end
    drop = xfer & ~bus.in_bcast & ~sel_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (load[i]) begin
          valid_q[i] <= 1'b1;
          data_q[i]  <= bus.in_data;
        end else if (bus.out_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // A clear that coincides with a drop leaves that drop recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err  <= 1'b0;
      drop_cnt <= '0;
    end else if (err_clr) begin
      sel_err  <= drop;
      drop_cnt <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      sel_err <= 1'b1;
      if (drop_cnt != {CNT_W{1'b1}}) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
endmodule

// File: tb/tb_stream_demux_1_to_n.sv
// Randomized scoreboard bench for stream_demux_1_to_n (N_CH=5, DATA_W=4, CNT_W=8).
// Expected words are queued per channel on acceptance; a negedge monitor pops and compares on drain.
module tb_stream_demux_1_to_n;
  localparam int N_CH   = 5;
  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             err_clr = 1'b0;
  logic             sel_err;
  logic [CNT_W-1:0] drop_cnt;

  stream_demux_1_to_n_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

  stream_demux_1_to_n #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .err_clr  (err_clr),
    .sel_err  (sel_err),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: each channel holds at most one word, so a queue per channel is its contents.
  logic [DATA_W-1:0] exp_q [N_CH][$];
  int                m_cnt = 0;
  logic              m_err = 1'b0;

  logic              pend_acc   = 1'b0;
  logic              pend_bcast = 1'b0;
  logic              pend_clr   = 1'b0;
  logic [SEL_W-1:0]  pend_sel   = '0;
  logic [DATA_W-1:0] pend_dat   = '0;
  logic [DATA_W-1:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic [SEL_W-1:0] sel, input logic bc,
                                       input logic [N_CH-1:0] ordy);
    if (bc) begin
      for (int i = 0; i < N_CH; i++)
        if (exp_q[i].size() != 0 && !ordy[i]) return 1'b0;
      return 1'b1;
    end
    if (int'(sel) >= N_CH) return 1'b1;
    return (exp_q[sel].size() == 0) || ordy[sel];
  endfunction

  task automatic apply_pending();
    logic drop;
    drop = pend_acc && !pend_bcast && (int'(pend_sel) >= N_CH);
    if (pend_acc) begin
      if (pend_bcast) begin
        for (int i = 0; i < N_CH; i++) exp_q[i].push_back(pend_dat);
      end else if (int'(pend_sel) < N_CH) begin
        exp_q[pend_sel].push_back(pend_dat);
      end
    end
    if (pend_clr) begin
      m_err = drop;
      m_cnt = drop ? 1 : 0;
    end else if (drop) begin
      m_err = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    pend_acc = 1'b0;
    pend_clr = 1'b0;
  endtask

  task automatic cycle(input logic v, input logic [SEL_W-1:0] sel, input logic bc,
                       input logic [DATA_W-1:0] d, input logic [N_CH-1:0] ordy, input logic clr);
    logic exp_rdy;
    @(posedge clk);
    apply_pending();
    #1;
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_bcast  = bc;
    bus.in_data   = d;
    bus.out_ready = ordy;
    err_clr       = clr;
    exp_rdy = model_ready(sel, bc, ordy);
    @(negedge clk);
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    check("sel_err", 64'(sel_err), 64'(m_err));
    check("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
    pend_acc   = v & exp_rdy;
    pend_bcast = bc;
    pend_sel   = sel;
    pend_dat   = d;
    pend_clr   = clr;
  endtask

  task automatic idle(input logic [N_CH-1:0] ordy);
    cycle(1'b0, '0, 1'b0, '0, ordy, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, " out_data"}, 64'(bus.out_data), 64'(0));
    check({tag, " sel_err"}, 64'(sel_err), 64'(0));
    check({tag, " drop_cnt"}, 64'(drop_cnt), 64'(0));
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'(1));
  endtask

  // Monitor: model occupancy must match out_valid; a drain pops and compares the word.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        check($sformatf("occupancy ch%0d", i), 64'(bus.out_valid[i]),
              64'(exp_q[i].size() != 0));
        if (bus.out_valid[i] && bus.out_ready[i] && exp_q[i].size() != 0) begin
          mon_exp = exp_q[i].pop_front();
          check($sformatf("data ch%0d", i), 64'(bus.out_data[i*DATA_W +: DATA_W]),
                64'(mon_exp));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_bcast  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '1;
    #1;
    check_reset_state("reset");
    #21 rst_n = 1'b1;

    // Unicast sweep over every legal channel, consumers always ready.
    for (int s = 0; s < N_CH; s++) cycle(1'b1, SEL_W'(s), 1'b0, 4'h1, '1, 1'b0);
    idle('1);
    idle('1);

    // Back-pressure on ch3 blocks only ch3; release drains and reloads on one edge.
    cycle(1'b1, 3'd3, 1'b0, 4'hA, 5'b10111, 1'b0);
    cycle(1'b1, 3'd3, 1'b0, 4'hB, 5'b10111, 1'b0);
    cycle(1'b1, 3'd1, 1'b0, 4'hC, 5'b10111, 1'b0);
    cycle(1'b1, 3'd3, 1'b0, 4'hB, 5'b11111, 1'b0);
    idle(5'b10111);
    check("ch3 reload data", 64'(bus.out_data[3*DATA_W +: DATA_W]), 64'(4'hB));
    idle('1);

    // Out-of-range drops until the counter saturates.
    for (int k = 0; k < 300; k++) cycle(1'b1, 3'd6, 1'b0, 4'hA, '1, 1'b0);
    idle('1);
    check("drop_cnt saturated", 64'(drop_cnt), 64'(255));
    check("sel_err sticky", 64'(sel_err), 64'(1));

    // Clear coinciding with a drop, then clear alone.
    cycle(1'b1, 3'd7, 1'b0, 4'h3, '1, 1'b1);
    idle('1);
    check("clr+drop drop_cnt", 64'(drop_cnt), 64'(1));
    check("clr+drop sel_err", 64'(sel_err), 64'(1));
    cycle(1'b0, 3'd0, 1'b0, 4'h0, '1, 1'b1);
    idle('1);
    check("clr drop_cnt", 64'(drop_cnt), 64'(0));
    check("clr sel_err", 64'(sel_err), 64'(0));

    // Broadcast stalls behind a held ch2, then loads every channel atomically.
    cycle(1'b1, 3'd2, 1'b0, 4'h7, 5'b11011, 1'b0);
    cycle(1'b1, 3'd0, 1'b1, 4'h5, 5'b11011, 1'b0);
    check("bcast stalled", 64'(bus.out_valid), 64'(5'b00100));
    cycle(1'b1, 3'd0, 1'b1, 4'h5, 5'b11111, 1'b0);
    idle('0);
    check("bcast all loaded", 64'(bus.out_valid), 64'(5'b11111));
    check("bcast data", 64'(bus.out_data), 64'({5{4'h5}}));
    idle('1);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [N_CH-1:0] ordy;
      for (int i = 0; i < N_CH; i++) ordy[i] = ($urandom % 4) != 0;
      cycle(($urandom % 4) != 0, SEL_W'($urandom_range(0, 7)), ($urandom % 8) == 0,
            DATA_W'($urandom), ordy, ($urandom % 32) == 0);
    end
    idle('1);

    // Reset with three channels holding words.
    cycle(1'b1, 3'd0, 1'b0, 4'h9, '0, 1'b0);
    cycle(1'b1, 3'd1, 1'b0, 4'hE, '0, 1'b0);
    cycle(1'b1, 3'd4, 1'b0, 4'h6, '0, 1'b0);
    idle('0);
    check("held before reset", 64'(bus.out_valid), 64'(5'b10011));
    bus.in_valid = 1'b0;
    bus.in_sel   = '0;
    bus.in_bcast = 1'b0;
    err_clr      = 1'b0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < N_CH; i++) exp_q[i].delete();
    pend_acc = 1'b0;
    pend_clr = 1'b0;
    m_err    = 1'b0;
    m_cnt    = 0;
    #1;
    check_reset_state("midreset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("first cycle in_ready", 64'(bus.in_ready), 64'(1));
    cycle(1'b1, 3'd4, 1'b0, 4'hD, '1, 1'b0);
    repeat (3) idle('1);
    check("final drained", 64'(bus.out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
